// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router types, input-unit state encoding and XY route helper
package router_pkg;

    localparam int FLIT_SIZE_DEF = 19;
    localparam int XY_W          = 16;

    localparam int ERR_MISSING_TAIL = 0;
    localparam int ERR_ORPHAN       = 1;
    localparam int ERR_OVERFLOW     = 2;

    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } FLIT_TYPE_t;

    typedef enum logic [2:0] {
        LOCAL_PORT = 3'd0,
        NORTH_PORT = 3'd1,
        SOUTH_PORT = 3'd2,
        EAST_PORT  = 3'd3,
        WEST_PORT  = 3'd4,
        NONE_PORT  = 3'd7
    } PORT_t;

    typedef struct packed {
        logic                     valid;
        FLIT_TYPE_t               ftype;
        logic [FLIT_SIZE_DEF-4:0] data;
    } FLIT_t;

    typedef enum logic {
        IU_IDLE   = 1'b0,
        IU_ACTIVE = 1'b1
    } IU_STATE_t;

    // Callers zero-extend their ADDR_W coordinates, so the compares stay unsigned.
    function automatic PORT_t xy_route(input logic [XY_W-1:0] dst_x, input logic [XY_W-1:0] dst_y,
                                       input logic [XY_W-1:0] own_x, input logic [XY_W-1:0] own_y);
        if (dst_x > own_x)      return EAST_PORT;
        else if (dst_x < own_x) return WEST_PORT;
        else if (dst_y > own_y) return NORTH_PORT;
        else if (dst_y < own_y) return SOUTH_PORT;
        else                    return LOCAL_PORT;
    endfunction

endpackage

// File: rtl/router_flit_fifo.sv
// rtl/router_flit_fifo.sv - DEPTH-entry flit FIFO with modulo-DEPTH pointers and occupancy count
module router_flit_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/router_input_unit.sv
// rtl/router_input_unit.sv - router input port: flit buffer, XY routing with wormhole lock, credits
module router_input_unit
    import router_pkg::*;
#(
    parameter int FLIT_SIZE = 19,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = (FLIT_SIZE - 3) / 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    cfg_xaddr,
    input  logic [ADDR_W-1:0]    cfg_yaddr,
    input  logic                 in_valid,
    input  logic [FLIT_SIZE-1:0] in_flit,
    output logic [1:0]           credit_o,
    output logic                 out_req,
    output logic [FLIT_SIZE-1:0] out_flit,
    output logic [2:0]           out_port,
    input  logic                 out_grant,
    output logic [CNT_W-1:0]     fifo_count,
    output logic [2:0]           err_o
);

    IU_STATE_t            state_q, state_d;
    PORT_t                route_q, route_d;
    logic                 head_sent_q, head_sent_d;
    logic [1:0]           credit_q, credit_d;
    logic [2:0]           err_q, err_d;

    logic [FLIT_SIZE-1:0] front;
    logic                 fifo_full, fifo_empty;
    logic                 pop, push_acc, in_ok, discard;
    FLIT_TYPE_t           in_type, front_type;
    PORT_t                front_route;

    assign in_type    = FLIT_TYPE_t'(in_flit[FLIT_SIZE-2 -: 2]);
    assign front_type = FLIT_TYPE_t'(front[FLIT_SIZE-2 -: 2]);
    assign in_ok      = in_flit[FLIT_SIZE-1] && (in_type != NONE_FLIT);
    assign discard    = in_valid && !in_ok;

    assign front_route = xy_route(XY_W'(front[2*ADDR_W-1 -: ADDR_W]), XY_W'(front[ADDR_W-1:0]),
                                  XY_W'(cfg_xaddr), XY_W'(cfg_yaddr));

    router_flit_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_acc),
        .push_data (in_flit),
        .pop       (pop),
        .pop_data  (front),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        head_sent_d = head_sent_q;
        err_d       = err_q;
        pop         = 1'b0;
        out_req     = 1'b0;
        case (state_q)
            IU_IDLE: begin
                if (!fifo_empty) begin
                    if (front_type == HEAD_FLIT) begin
                        route_d     = front_route;
                        head_sent_d = 1'b0;
                        state_d     = IU_ACTIVE;
                    end else begin
                        pop               = 1'b1;
                        err_d[ERR_ORPHAN] = 1'b1;
                    end
                end
            end
            IU_ACTIVE: begin
                if (!fifo_empty) begin
                    // A second head after ours left means the tail was lost: re-route for
                    // the new packet and hold the request off for this one cycle.
                    if (front_type == HEAD_FLIT && head_sent_q) begin
                        err_d[ERR_MISSING_TAIL] = 1'b1;
                        route_d                 = front_route;
                        head_sent_d             = 1'b0;
                    end else begin
                        out_req = 1'b1;
                        if (out_grant) begin
                            pop = 1'b1;
                            if (front_type == HEAD_FLIT) begin
                                head_sent_d = 1'b1;
                            end
                            if (front_type == TAIL_FLIT) begin
                                state_d = IU_IDLE;
                                route_d = NONE_PORT;
                            end
                        end
                    end
                end
            end
            default: state_d = IU_IDLE;
        endcase

        push_acc = in_valid && in_ok && (!fifo_full || pop);
        if (in_valid && in_ok && !push_acc) begin
            err_d[ERR_OVERFLOW] = 1'b1;
        end
        credit_d = {1'b0, pop} + {1'b0, discard};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IU_IDLE;
            route_q     <= NONE_PORT;
            head_sent_q <= 1'b0;
            credit_q    <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            head_sent_q <= head_sent_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
        end
    end

    assign out_flit = front;
    assign out_port = route_q;
    assign credit_o = credit_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_router_input_unit.sv
// tb/tb_router_input_unit.sv - self-checking bench: vector table, corner sequences, random vs queue model
module tb_router_input_unit;

    localparam int CX = 2;
    localparam int CY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [18:0] in_flit;
    logic [1:0]  credit_o;
    logic        out_req;
    logic [18:0] out_flit;
    logic [2:0]  out_port;
    logic        out_grant;
    logic [2:0]  fifo_count;
    logic [2:0]  err_o;

    int checks = 0;
    int errors = 0;

    router_input_unit #(.FLIT_SIZE(19), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_xaddr  (8'd2),
        .cfg_yaddr  (8'd2),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .credit_o   (credit_o),
        .out_req    (out_req),
        .out_flit   (out_flit),
        .out_port   (out_port),
        .out_grant  (out_grant),
        .fifo_count (fifo_count),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: a packet is either open or not; its route is fixed from its head.
    logic [18:0] q[$];
    bit          m_open;
    bit          m_head_waiting;
    int          m_route;
    logic [2:0]  m_err;
    int          m_credit;

    function automatic logic [18:0] mk(input int t, input int x, input int y);
        logic [18:0] f;
        f = {1'b1, t[1:0], x[7:0], y[7:0]};
        return f;
    endfunction

    function automatic int ref_route(input logic [18:0] f);
        int dx = int'(f[15:8]);
        int dy = int'(f[7:0]);
        if (dx > CX) return 3;
        if (dx < CX) return 4;
        if (dy > CY) return 1;
        if (dy < CY) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_open         = 0;
        m_head_waiting = 0;
        m_route        = 7;
        m_err          = 3'b000;
        m_credit       = 0;
    endfunction

    function automatic void model_step(input logic v, input logic [18:0] f, input logic g);
        int pops = 0;
        int disc;
        bit ok = v && f[18] && (f[17:16] != 2'd0);
        disc = (v && !ok) ? 1 : 0;
        if (q.size() > 0) begin
            int t = int'(q[0][17:16]);
            if (!m_open) begin
                if (t == 1) begin
                    m_route = ref_route(q[0]); m_open = 1; m_head_waiting = 1;
                end else begin
                    pops = 1; m_err[1] = 1'b1;
                end
            end else if (t == 1 && !m_head_waiting) begin
                m_err[0] = 1'b1; m_route = ref_route(q[0]); m_head_waiting = 1;
            end else if (g) begin
                pops = 1;
                if (t == 1) m_head_waiting = 0;
                if (t == 3) m_open = 0;
            end
        end
        if (pops == 1) void'(q.pop_front());
        if (ok) begin
            if (q.size() < 4) q.push_back(f);
            else m_err[2] = 1'b1;
        end
        m_credit = pops + disc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit req;
        req = m_open && (q.size() > 0);
        if (req && q[0][17:16] == 2'd1 && !m_head_waiting) req = 0;
        chk("m_req", 32'(out_req), 32'(req));
        if (req) begin
            chk("m_port", 32'(out_port), 32'(m_route));
            chk("m_flit", 32'(out_flit), 32'(q[0]));
        end
        chk("m_count", 32'(fifo_count), 32'(q.size()));
        chk("m_credit", 32'(credit_o), 32'(m_credit));
        chk("m_err", 32'(err_o), 32'(m_err));
    endtask

    task automatic cycle(input logic v, input logic [18:0] f, input logic g);
        in_valid  = v;
        in_flit   = f;
        out_grant = g;
        model_step(v, f, g);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_flit   = '0;
        out_grant = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_req", 32'(out_req), 0);
        chk("rst_credit", 32'(credit_o), 0);
        chk("rst_err", 32'(err_o), 0);
    endtask

    typedef struct {
        logic        v;
        logic [18:0] f;
        logic        g;
        logic        req;
        logic [2:0]  port;
        logic [1:0]  ftype;
        logic [2:0]  cnt;
        logic [1:0]  cr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int credit_sum;
        logic [18:0] hflit;
        int dests[3][3];

        tbl[0] = '{1'b1, mk(1, 3, 2), 1'b1, 1'b0, 3'd0, 2'd0, 3'd1, 2'd0};
        tbl[1] = '{1'b1, mk(2, 0, 9), 1'b1, 1'b1, 3'd3, 2'd1, 3'd2, 2'd0};
        tbl[2] = '{1'b1, mk(2, 5, 6), 1'b1, 1'b1, 3'd3, 2'd2, 3'd2, 2'd1};
        tbl[3] = '{1'b1, mk(3, 7, 1), 1'b1, 1'b1, 3'd3, 2'd2, 3'd2, 2'd1};
        tbl[4] = '{1'b0, 19'd0,       1'b1, 1'b1, 3'd3, 2'd3, 3'd1, 2'd1};
        tbl[5] = '{1'b0, 19'd0,       1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd1};
        tbl[6] = '{1'b0, 19'd0,       1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 2'd0};

        apply_reset();

        credit_sum = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].v, tbl[i].f, tbl[i].g);
            chk("t1_req", 32'(out_req), 32'(tbl[i].req));
            if (tbl[i].req) begin
                chk("t1_port", 32'(out_port), 32'(tbl[i].port));
                chk("t1_type", 32'(out_flit[17:16]), 32'(tbl[i].ftype));
            end
            chk("t1_count", 32'(fifo_count), 32'(tbl[i].cnt));
            chk("t1_credit", 32'(credit_o), 32'(tbl[i].cr));
            credit_sum += int'(credit_o);
        end
        chk("t1_credit_total", 32'(credit_sum), 4);

        dests = '{'{2, 2, 0}, '{2, 0, 2}, '{1, 5, 4}};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, mk(1, dests[i][0], dests[i][1]), 1'b1);
            cycle(1'b1, mk(3, 0, 0), 1'b1);
            chk("t2_req", 32'(out_req), 1);
            chk("t2_port", 32'(out_port), 32'(dests[i][2]));
            repeat (3) cycle(1'b0, '0, 1'b1);
        end

        apply_reset();
        cycle(1'b1, mk(2, 1, 1), 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("t3_err", 32'(err_o), 32'h2);
        chk("t3_credit", 32'(credit_o), 1);
        chk("t3_count", 32'(fifo_count), 0);
        cycle(1'b0, '0, 1'b1);
        chk("t3_credit_once", 32'(credit_o), 0);
        chk("t3_req", 32'(out_req), 0);

        apply_reset();
        hflit = mk(1, 4, 4);
        cycle(1'b1, hflit, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, mk(2, i, i), 1'b0);
            if (i >= 1) chk("t4_flit_stable", 32'(out_flit), 32'(hflit));
        end
        chk("t4_count", 32'(fifo_count), 4);
        chk("t4_overflow", 32'(err_o), 32'h4);
        chk("t4_credit", 32'(credit_o), 0);

        apply_reset();
        cycle(1'b1, mk(1, 3, 2), 1'b1);
        cycle(1'b1, mk(2, 0, 0), 1'b1);
        cycle(1'b1, mk(1, 2, 4), 1'b1);
        cycle(1'b1, mk(3, 0, 0), 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("t5_err", 32'(err_o), 32'h1);
        chk("t5_req", 32'(out_req), 1);
        chk("t5_port", 32'(out_port), 1);
        repeat (3) cycle(1'b0, '0, 1'b1);

        apply_reset();
        cycle(1'b1, mk(3, 0, 0), 1'b0);
        cycle(1'b1, mk(1, 3, 3), 1'b0);
        cycle(1'b1, mk(2, 0, 0), 1'b0);
        cycle(1'b1, mk(2, 0, 0), 1'b0);
        cycle(1'b1, {1'b0, 18'h1234}, 1'b0);
        chk("t6_pre_count", 32'(fifo_count), 3);
        chk("t6_pre_credit", 32'(credit_o), 1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("t6_count", 32'(fifo_count), 0);
        chk("t6_req", 32'(out_req), 0);
        chk("t6_err", 32'(err_o), 0);
        chk("t6_credit", 32'(credit_o), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_model();

        for (int n = 0; n < 3000; n++) begin
            logic [18:0] f;
            f = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 9) == 0) f[18] = 1'b0;
            cycle($urandom_range(0, 9) < 6, f, $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
